store_rmw_unit: RTL and testbench

- Store-side companion to the load path: executes sb/sh/sw from the MEM stage into a data memory that accepts only full 32-bit words (no byte enables).
- Word stores are a single write.
- Byte and halfword stores are read-modify-write: read the word, merge the lane, write the word back.
- Stalls the pipeline through a valid/ready handshake; reports misaligned accesses and memory timeouts.

---
 rtl/store_pkg.sv | 21 ++
 rtl/store_merge.sv | 44 ++++
 rtl/store_rmw_unit.sv | 171 +++++++++++++++++
 tb/tb_store_rmw_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared encodings and defaults for the store read-modify-write unit.
package store_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned ACK_TIMEOUT_DEF = 255;

  // req_size encodings
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/store_merge.sv
// Lane merge for sub-word stores plus access legality decode.
//   old_word : word read from memory (ignored for word stores)
//   wdata    : store data, byte/half taken from the low bits
//   addr_lo  : byte offset within the word
//   size     : SIZE_BYTE / SIZE_HALF / SIZE_WORD / SIZE_RSVD
//   merged   : word to write back
//   misalign : access cannot be performed (misaligned or reserved size)
module store_merge
  import store_pkg::*;
(
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  output logic [DATA_W-1:0] merged,
  output logic              misalign
);

  always_comb begin
    merged   = old_word;
    misalign = 1'b0;
    case (size)
      SIZE_BYTE: begin
        case (addr_lo)
          2'b00:   merged[7:0]   = wdata[7:0];
          2'b01:   merged[15:8]  = wdata[7:0];
          2'b10:   merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
        misalign = addr_lo[0];
      end
      SIZE_WORD: begin
        merged   = wdata;
        misalign = (addr_lo != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit for a word-only data memory: sw is a single write, sb/sh are
// read-modify-write. Handshakes with the MEM stage, flags misaligned or
// reserved-size requests and aborts accesses whose ack never arrives.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : request handshake from MEM stage
//   req_addr/wdata/size   : byte address, store data, access size
//   req_done/req_err      : one-cycle completion pulse and error flag
//   mem_addr/re/we/wdata  : word-aligned memory request, strobes held to ack
//   mem_rdata/mem_ack     : memory read data and one-cycle completion
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  output logic              req_done,
  output logic              req_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  // Last strobe cycle index; counter starts at 0 on the first strobe cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        lo_q, lo_d;
  logic [1:0]        size_q, size_d;

  logic              ready_d, done_d, err_d, re_d, we_d;
  logic [ADDR_W-1:0] maddr_d;
  logic [DATA_W-1:0] mwdata_d;

  logic [DATA_W-1:0] m_wdata, merged;
  logic [1:0]        m_lo, m_size;
  logic              misalign;

  // In IDLE the merge decodes the incoming request; afterwards it merges the
  // captured store into mem_rdata, so the read word lands directly in
  // mem_wdata on the read ack instead of a separate holding register.
  assign m_wdata = (state_q == IDLE) ? req_wdata     : wdata_q;
  assign m_lo    = (state_q == IDLE) ? req_addr[1:0] : lo_q;
  assign m_size  = (state_q == IDLE) ? req_size      : size_q;

  store_merge u_merge (
    .old_word (mem_rdata),
    .wdata    (m_wdata),
    .addr_lo  (m_lo),
    .size     (m_size),
    .merged   (merged),
    .misalign (misalign)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wdata_q   <= '0;
      lo_q      <= '0;
      size_q    <= '0;
      req_ready <= 1'b1;
      req_done  <= 1'b0;
      req_err   <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wdata_q   <= wdata_d;
      lo_q      <= lo_d;
      size_q    <= size_d;
      req_ready <= ready_d;
      req_done  <= done_d;
      req_err   <= err_d;
      mem_re    <= re_d;
      mem_we    <= we_d;
      mem_addr  <= maddr_d;
      mem_wdata <= mwdata_d;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wdata_d  = wdata_q;
    lo_d     = lo_q;
    size_d   = size_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    re_d     = 1'b0;
    we_d     = 1'b0;
    maddr_d  = mem_addr;
    mwdata_d = mem_wdata;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wdata_d = req_wdata;
          lo_d    = req_addr[1:0];
          size_d  = req_size;
          if (misalign) begin
            state_d = RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            maddr_d = {req_addr[ADDR_W-1:2], 2'b00};
            cnt_d   = '0;
            if (req_size == SIZE_WORD) begin
              state_d  = WRITE;
              we_d     = 1'b1;
              mwdata_d = merged;
            end else begin
              state_d = READ;
              re_d    = 1'b1;
            end
          end
        end
      end
      READ: begin
        // Ack wins over a timeout in the same cycle.
        if (mem_ack) begin
          state_d  = WRITE;
          we_d     = 1'b1;
          cnt_d    = '0;
          mwdata_d = merged;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          re_d  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WRITE: begin
        if (mem_ack) begin
          state_d = RESP;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          we_d  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Self-checking bench for store_rmw_unit: directed cases plus randomized
// stores checked against a behavioural memory model.
module tb_store_rmw_unit;

  localparam int unsigned ADDR_W  = 32;
  localparam int          TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_done;
  logic        req_err;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  always #5 clk = ~clk;

  store_rmw_unit #(.ADDR_W(ADDR_W), .ACK_TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .req_done  (req_done),
    .req_err   (req_err),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory seen by the DUT, and the bench's own expectation of its contents.
  logic [31:0] mem     [bit [31:0]];
  logic [31:0] ref_mem [bit [31:0]];

  int          ack_delay = 0;
  bit          no_ack    = 1'b0;
  bit          stray_req = 1'b0;
  int          wcnt      = 0;
  int          re_cycles = 0;
  int          we_cycles = 0;
  logic [31:0] rd_addr_last;
  logic [63:0] wlog[$];

  // Memory responder: acks a strobe ack_delay cycles after it is first seen.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!rst_n) begin
      wcnt = 0;
    end else if (stray_req) begin
      mem_ack = 1'b1;
    end else if (mem_re || mem_we) begin
      if (mem_re) re_cycles++;
      if (mem_we) we_cycles++;
      if (!no_ack && wcnt == ack_delay) begin
        mem_ack = 1'b1;
        wcnt    = 0;
        if (mem_re) begin
          rd_addr_last = mem_addr;
          mem_rdata    = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        end
        if (mem_we) begin
          wlog.push_back({mem_addr, mem_wdata});
          mem[mem_addr] = mem_wdata;
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] lo, input logic [1:0] sz);
    int          sh;
    logic [31:0] mask;
    if (sz == 2'd0) begin
      sh   = 8 * int'(lo);
      mask = 32'hFF << sh;
      return (old & ~mask) | ((wd & 32'hFF) << sh);
    end
    if (sz == 2'd1) begin
      sh   = 16 * int'(lo[1]);
      mask = 32'hFFFF << sh;
      return (old & ~mask) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  function automatic bit ref_bad(input logic [1:0] lo, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && lo[0]) || (sz == 2'd2 && lo != 2'd0);
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  // Issue one store, hold it until done and check everything observable.
  task automatic do_store(input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, input int delay);
    logic [31:0] wa;
    logic [31:0] exp_word;
    bit          bad, is_word, exp_err;
    int          exp_lat, exp_re, exp_we, exp_wr, k;
    wa       = {addr[31:2], 2'b00};
    bad      = ref_bad(addr[1:0], sz);
    is_word  = (sz == 2'd2);
    exp_word = ref_merge(ref_mem.exists(wa) ? ref_mem[wa] : 32'h0, wd, addr[1:0], sz);
    if (bad) begin
      exp_err = 1'b1; exp_lat = 1; exp_re = 0; exp_we = 0; exp_wr = 0;
    end else if (no_ack) begin
      exp_err = 1'b1; exp_lat = TIMEOUT + 1; exp_wr = 0;
      exp_re  = is_word ? 0 : TIMEOUT;
      exp_we  = is_word ? TIMEOUT : 0;
    end else begin
      exp_err = 1'b0; exp_wr = 1; exp_we = delay + 1;
      exp_re  = is_word ? 0 : delay + 1;
      exp_lat = is_word ? 2 + delay : 3 + 2 * delay;
    end

    check("ready_before", 32'(req_ready), 32'd1);
    ack_delay    = delay;
    re_cycles    = 0;
    we_cycles    = 0;
    rd_addr_last = 32'hFFFF_FFFF;
    wlog.delete();
    req_addr  = addr;
    req_wdata = wd;
    req_size  = sz;
    req_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!req_done && k < 2000);
    req_valid = 1'b0;

    check("done_seen", 32'(req_done), 32'd1);
    check("latency", 32'(k), 32'(exp_lat));
    check("err", 32'(req_err), 32'(exp_err));
    check("re_cycles", 32'(re_cycles), 32'(exp_re));
    check("we_cycles", 32'(we_cycles), 32'(exp_we));
    check("writes", 32'(wlog.size()), 32'(exp_wr));
    if (exp_re > 0 && !no_ack) check("rd_addr", rd_addr_last, wa);
    if (exp_wr == 1 && wlog.size() == 1) begin
      check("wr_addr", wlog[0][63:32], wa);
      check("wr_data", wlog[0][31:0], exp_word);
      ref_mem[wa] = exp_word;
    end
    @(negedge clk);
    check("done_pulse", 32'(req_done), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) set_word(32'h100 + 32'(i * 4), $urandom);
    set_word(32'h100, 32'h11223344);

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_done", 32'(req_done), 32'd0);
    check("rst_err", 32'(req_err), 32'd0);
    check("rst_re", 32'(mem_re), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_maddr", mem_addr, 32'h0);
    check("rst_mwdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store
    do_store(32'h100, 32'hDEADBEEF, 2'd2, 2);
    check("sw_mem", mem[32'h100], 32'hDEADBEEF);

    // Byte stores into each lane
    set_word(32'h100, 32'h11223344);
    do_store(32'h103, 32'h000000AA, 2'd0, 0);
    check("sb_lane3", mem[32'h100], 32'hAA223344);
    set_word(32'h100, 32'h11223344);
    do_store(32'h100, 32'h000000AA, 2'd0, 1);
    check("sb_lane0", mem[32'h100], 32'h112233AA);
    set_word(32'h100, 32'h11223344);
    do_store(32'h101, 32'h000000AA, 2'd0, 0);
    check("sb_lane1", mem[32'h100], 32'h1122AA44);
    set_word(32'h100, 32'h11223344);
    do_store(32'h102, 32'h000000AA, 2'd0, 3);
    check("sb_lane2", mem[32'h100], 32'h11AA3344);

    // Halfword stores
    set_word(32'h100, 32'h11223344);
    do_store(32'h102, 32'h00005566, 2'd1, 0);
    check("sh_hi", mem[32'h100], 32'h55663344);
    set_word(32'h100, 32'h11223344);
    do_store(32'h100, 32'h00005566, 2'd1, 0);
    check("sh_lo", mem[32'h100], 32'h11225566);

    // Illegal requests
    do_store(32'h101, 32'h12345678, 2'd1, 0);
    do_store(32'h102, 32'h12345678, 2'd2, 0);
    do_store(32'h104, 32'h12345678, 2'd3, 0);

    // Timeout, then ack on the last allowed cycle
    no_ack = 1'b1;
    do_store(32'h105, 32'h000000CC, 2'd0, 0);
    no_ack = 1'b0;
    do_store(32'h106, 32'h000000DD, 2'd0, TIMEOUT - 1);

    // Reset in the middle of a read
    no_ack    = 1'b1;
    req_addr  = 32'h108;
    req_wdata = 32'h000000EE;
    req_size  = 2'd0;
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_re", 32'(mem_re), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_re", 32'(mem_re), 32'd0);
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    no_ack = 1'b0;
    @(negedge clk);
    stray_req = 1'b1;
    @(negedge clk);
    stray_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_strobe", 32'({mem_re, mem_we}), 32'd0);
      check("stray_done", 32'(req_done), 32'd0);
    end
    do_store(32'h10C, 32'hCAFEF00D, 2'd2, 1);
    check("post_rst_sw", mem[32'h10C], 32'hCAFEF00D);

    // Randomized stores
    for (int i = 0; i < 80; i++) begin
      do_store(32'h100 + 32'($urandom_range(0, 63)), $urandom,
               2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 16; i++) begin
      check("final_mem", mem[32'h100 + 32'(i * 4)], ref_mem[32'h100 + 32'(i * 4)]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
